// File: rtl/vec3_normalize_seq.sv
// Multi-cycle Q8.4 vector normalizer: squares, iterative isqrt, then three
// restoring divisions (x, y, z) produce n = v/|v| and |v| behind valid/ready.
module vec3_normalize_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_nx,
    output logic [WIDTH-1:0] out_ny,
    output logic [WIDTH-1:0] out_nz,
    output logic [WIDTH-1:0] out_len,
    output logic             out_zero,
    output logic             busy
);

    localparam int SUMW = 2*WIDTH + 2;
    localparam int RW   = WIDTH + 1;
    localparam int SRW  = WIDTH + 2;
    localparam int DVW  = WIDTH + 4;
    localparam int CNTW = $clog2(DVW);

    typedef enum logic [2:0] {IDLE, SQ, SQRT, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [1:0]        comp_q, comp_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [SUMW-1:0]   sum_q, sum_d;
    logic [RW-1:0]     root_q, root_d;
    logic [SRW-1:0]    srem_q, srem_d;
    logic [DVW-1:0]    dvd_q, dvd_d;
    logic [WIDTH-1:0]  drem_q, drem_d;
    logic [WIDTH-2:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  res_x_q, res_x_d, res_y_q, res_y_d;
    logic [WIDTH-1:0]  nx_q, nx_d, ny_q, ny_d, nz_q, nz_d, len_q, len_d;
    logic              zero_q, zero_d;

    logic [WIDTH-1:0]  mag_x, mag_y, mag_z, len, cur_c, nxt_mag, q_signed;
    logic [SUMW-1:0]   sum_calc;
    logic [SRW+1:0]    rem_next, trial;
    logic              sqrt_bit, div_bit;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  quo_new;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_nx    = nx_q;
    assign out_ny    = ny_q;
    assign out_nz    = nz_q;
    assign out_len   = len_q;
    assign out_zero  = zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            comp_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sum_q   <= '0;
            root_q  <= '0;
            srem_q  <= '0;
            dvd_q   <= '0;
            drem_q  <= '0;
            quo_q   <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            nz_q    <= '0;
            len_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sum_q   <= sum_d;
            root_q  <= root_d;
            srem_q  <= srem_d;
            dvd_q   <= dvd_d;
            drem_q  <= drem_d;
            quo_q   <= quo_d;
            res_x_q <= res_x_d;
            res_y_q <= res_y_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            nz_q    <= nz_d;
            len_q   <= len_d;
            zero_q  <= zero_d;
        end
    end

    // Datapath helpers: magnitudes, one isqrt step and one division step.
    always_comb begin
        mag_x    = x_q[WIDTH-1] ? -x_q : x_q;
        mag_y    = y_q[WIDTH-1] ? -y_q : y_q;
        mag_z    = z_q[WIDTH-1] ? -z_q : z_q;
        sum_calc = SUMW'(mag_x) * SUMW'(mag_x) + SUMW'(mag_y) * SUMW'(mag_y)
                 + SUMW'(mag_z) * SUMW'(mag_z);
        len      = root_q[WIDTH-1:0];

        rem_next = {srem_q, sum_q[SUMW-1 -: 2]};
        trial    = {1'b0, root_q, 2'b01};
        sqrt_bit = (rem_next >= trial);

        cur_c    = (comp_q == 2'd0) ? x_q : ((comp_q == 2'd1) ? y_q : z_q);
        nxt_mag  = (comp_q == 2'd0) ? mag_y : mag_z;
        rem_sh   = {drem_q, dvd_q[DVW-1]};
        div_bit  = (rem_sh >= {1'b0, len});
        quo_new  = {quo_q, div_bit};
        q_signed = cur_c[WIDTH-1] ? -quo_new : quo_new;
    end

    // The remainder stays below 2*root, so dropping the top bits of the
    // difference is exact; the same holds for the divider remainder vs len.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        comp_d  = comp_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sum_d   = sum_q;
        root_d  = root_q;
        srem_d  = srem_q;
        dvd_d   = dvd_q;
        drem_d  = drem_q;
        quo_d   = quo_q;
        res_x_d = res_x_q;
        res_y_d = res_y_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        nz_d    = nz_q;
        len_d   = len_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    z_d     = in_z;
                    state_d = SQ;
                end
            end
            SQ: begin
                sum_d   = sum_calc;
                root_d  = '0;
                srem_d  = '0;
                cnt_d   = '0;
                state_d = SQRT;
            end
            SQRT: begin
                sum_d  = {sum_q[SUMW-3:0], 2'b00};
                root_d = {root_q[RW-2:0], sqrt_bit};
                srem_d = sqrt_bit ? (rem_next[SRW-1:0] - trial[SRW-1:0])
                                  : rem_next[SRW-1:0];
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(RW-1)) begin
                    cnt_d   = '0;
                    comp_d  = '0;
                    dvd_d   = {mag_x, 4'b0000};
                    drem_d  = '0;
                    quo_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (comp_q == 2'd0 && cnt_q == '0 && root_q == '0) begin
                    nx_d    = '0;
                    ny_d    = '0;
                    nz_d    = '0;
                    len_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dvd_d  = {dvd_q[DVW-2:0], 1'b0};
                    drem_d = div_bit ? (rem_sh[WIDTH-1:0] - len) : rem_sh[WIDTH-1:0];
                    quo_d  = quo_new[WIDTH-2:0];
                    cnt_d  = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(DVW-1)) begin
                        cnt_d  = '0;
                        comp_d = comp_q + 2'd1;
                        dvd_d  = {nxt_mag, 4'b0000};
                        drem_d = '0;
                        quo_d  = '0;
                        case (comp_q)
                            2'd0:    res_x_d = q_signed;
                            2'd1:    res_y_d = q_signed;
                            default: begin
                                nx_d    = res_x_q;
                                ny_d    = res_y_q;
                                nz_d    = q_signed;
                                len_d   = len;
                                zero_d  = 1'b0;
                                state_d = DONE;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vec3_normalize_seq.sv
// Scoreboard bench for vec3_normalize_seq: directed vectors with hand-computed
// results, decoupled driver and output monitor.
module tb_vec3_normalize_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] in_x = '0, in_y = '0, in_z = '0;
    logic        in_ready, out_valid, out_zero, busy;
    logic [11:0] out_nx, out_ny, out_nz, out_len;

    typedef struct {
        int nx; int ny; int nz; int len; int zero; int lat; int acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    logic prev_valid = 1'b0;
    int   n_asserts = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   out_count = 0;
    int   c;

    vec3_normalize_seq #(.WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
        .out_len(out_len), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp_v);
        n_asserts++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int nx, input int ny, input int nz,
                                input int len, input int zero, input int lat);
        exp_t e;
        e.nx = nx; e.ny = ny; e.nz = nz; e.len = len; e.zero = zero;
        e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Monitor: pop an expectation on each new result, then watch it stay put.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            out_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
                have_cur = 1'b0;
            end else begin
                cur = sb.pop_front();
                have_cur = 1'b1;
                checkOutput("latency", cyc - cur.acc - 1, cur.lat);
                checkOutput("out_nx", int'($signed(out_nx)), cur.nx);
                checkOutput("out_ny", int'($signed(out_ny)), cur.ny);
                checkOutput("out_nz", int'($signed(out_nz)), cur.nz);
                checkOutput("out_len", int'(out_len), cur.len);
                checkOutput("out_zero", int'(out_zero), cur.zero);
            end
        end else if (out_valid && have_cur) begin
            checkOutput("hold_stable",
                (int'($signed(out_nx)) == cur.nx && int'($signed(out_ny)) == cur.ny &&
                 int'($signed(out_nz)) == cur.nz && int'(out_len) == cur.len &&
                 int'(out_zero) == cur.zero) ? 1 : 0, 1);
        end
        prev_valid = out_valid;
    end

    task automatic applyStimulus(input int x, input int y, input int z,
                                 input exp_t e, input bit chk_now);
        int t;
        @(negedge clk);
        if (chk_now) checkOutput("accept_next_cycle", int'(in_ready), 1);
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        in_x = 12'(x);
        in_y = 12'(y);
        in_z = 12'(z);
        in_valid = 1'b1;
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_x = 12'(x + 5);
        checkOutput("in_ready_after_accept", int'(in_ready), 0);
    endtask

    task automatic waitResult(input int prev);
        int t;
        t = 0;
        while (out_count == prev && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (out_count == prev) checkOutput("result_timeout", 0, 1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_outs"}, int'({out_nx, out_ny, out_nz, out_len} == 48'd0), 1);
        checkOutput({tag, "_zero"}, int'(out_zero), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkIdleZero("reset");
        rst_n = 1'b1;

        c = out_count; applyStimulus(48, 0, 0, mk(16, 0, 0, 48, 0, 62), 1'b0); waitResult(c);
        c = out_count; applyStimulus(-48, 64, 0, mk(-9, 12, 0, 80, 0, 62), 1'b0); waitResult(c);
        c = out_count; applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 1, 15), 1'b0); waitResult(c);
        c = out_count; applyStimulus(-2048, -2048, -2048, mk(-9, -9, -9, 3547, 0, 62), 1'b0); waitResult(c);
        c = out_count; applyStimulus(16, 16, 16, mk(9, 9, 9, 27, 0, 62), 1'b0); waitResult(c);

        // Backpressure: result must hold and no new vector may slip in.
        out_ready = 1'b0;
        c = out_count; applyStimulus(0, -32, 0, mk(0, -16, 0, 32, 0, 62), 1'b0); waitResult(c);
        repeat (20) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_x = 12'($urandom);
            in_y = 12'($urandom);
            in_z = 12'($urandom);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        checkOutput("bp_out_valid", int'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_x = 12'd100;
        c = out_count; applyStimulus(48, 0, 0, mk(16, 0, 0, 48, 0, 62), 1'b1); waitResult(c);

        // Reset while in SQRT: the pending result is withdrawn from the scoreboard.
        c = out_count;
        applyStimulus(48, 64, 0, mk(12, 16, 0, 80, 0, 62), 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        checkIdleZero("midreset");
        repeat (80) @(negedge clk);
        checkOutput("no_output_after_reset", out_count, c);
        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("output_count", out_count, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
